xor4: RTL and testbench

XOR4 -- requirements
Module: xor4

---
 rtl/xor4.sv | 63 ++++++
 tb/tb_xor4.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/xor4.sv
// 4-bit parity unit with a registered parity, a valid strobe, a running
// parity accumulator and a saturating count of odd-parity samples.
//
// Ports:
//   clk       - rising-edge clock for all registered state
//   rst_n     - asynchronous active-low reset of all registered state
//   x         - 4-bit data word
//   in_valid  - sample x on the next rising edge
//   clear     - synchronous clear of registered state, wins over in_valid
//   y         - combinational parity of x (zero latency, reset-independent)
//   y_q       - parity of the last accepted x
//   y_valid   - one-cycle strobe following each accepted sample
//   acc       - running XOR of accepted parities since reset or clear
//   ones_cnt  - saturating count of accepted odd-parity samples
module xor4 #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       x,
  input  logic             in_valid,
  input  logic             clear,
  output logic             y,
  output logic             y_q,
  output logic             y_valid,
  output logic             acc,
  output logic [CNT_W-1:0] ones_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic accept;

  // Parity path is purely combinational so it tracks x even in reset.
  assign y      = ^x;
  assign accept = in_valid & ~clear;

  // Registered parity, strobe, accumulator and saturating counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q      <= 1'b0;
      y_valid  <= 1'b0;
      acc      <= 1'b0;
      ones_cnt <= '0;
    end else if (clear) begin
      y_q      <= 1'b0;
      y_valid  <= 1'b0;
      acc      <= 1'b0;
      ones_cnt <= '0;
    end else if (accept) begin
      y_q     <= y;
      y_valid <= 1'b1;
      acc     <= acc ^ y;
      // Hold at all-ones instead of wrapping.
      if (y && (ones_cnt != CNT_MAX)) begin
        ones_cnt <= ones_cnt + CNT_W'(1);
      end
    end else begin
      y_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_xor4.sv
// Scoreboard bench for xor4: a default-width instance and a CNT_W=2 instance
// for counter saturation. Stimulus pushes hand-computed expectations; monitors
// pop and compare whenever y_valid is seen.
module tb_xor4;

  typedef struct packed {
    logic       yq;
    logic       acc;
    logic [7:0] cnt;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] x;
  logic       in_valid;
  logic       in_valid2;
  logic       clear;

  logic       y8, yq8, yv8, acc8;
  logic [7:0] cnt8;
  logic       y2, yq2, yv2, acc2;
  logic [1:0] cnt2;

  exp_t q8[$];
  exp_t q2[$];

  int checks = 0;
  int errors = 0;

  logic [15:0] ytbl = 16'b0110_1001_1001_0110;

  xor4 #(.CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .x(x), .in_valid(in_valid), .clear(clear),
    .y(y8), .y_q(yq8), .y_valid(yv8), .acc(acc8), .ones_cnt(cnt8)
  );

  xor4 #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .x(x), .in_valid(in_valid2), .clear(clear),
    .y(y2), .y_q(yq2), .y_valid(yv2), .acc(acc2), .ones_cnt(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor for the 8-bit instance.
  always @(negedge clk) begin
    if (rst_n && yv8) begin
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mon8_unexpected_valid: got y_valid=1 expected no pending sample at %0t", $time);
      end else begin
        exp_t e;
        e = q8.pop_front();
        chk("mon8_y_q", 8'(yq8), 8'(e.yq));
        chk("mon8_acc", 8'(acc8), 8'(e.acc));
        chk("mon8_ones_cnt", cnt8, e.cnt);
      end
    end
  end

  // Monitor for the 2-bit-counter instance.
  always @(negedge clk) begin
    if (rst_n && yv2) begin
      if (q2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mon2_unexpected_valid: got y_valid=1 expected no pending sample at %0t", $time);
      end else begin
        exp_t e;
        e = q2.pop_front();
        chk("mon2_y_q", 8'(yq2), 8'(e.yq));
        chk("mon2_acc", 8'(acc2), 8'(e.acc));
        chk("mon2_ones_cnt", 8'(cnt2), e.cnt);
      end
    end
  end

  // Present one sample to the 8-bit instance; called at a falling edge.
  task automatic send8(input logic [3:0] xv, input logic eyq, input logic eacc,
                       input logic [7:0] ecnt);
    exp_t e;
    e.yq  = eyq;
    e.acc = eacc;
    e.cnt = ecnt;
    x        = xv;
    in_valid = 1'b1;
    q8.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic chk_regs_zero(input string tag);
    chk({tag, "_y_q"}, 8'(yq8), 8'h00);
    chk({tag, "_y_valid"}, 8'(yv8), 8'h00);
    chk({tag, "_acc"}, 8'(acc8), 8'h00);
    chk({tag, "_ones_cnt"}, cnt8, 8'h00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected end of stimulus");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst_n     = 1'b0;
    x         = 4'b0000;
    in_valid  = 1'b1;
    in_valid2 = 1'b1;
    clear     = 1'b0;
    #2;

    // Combinational sweep in reset, with samples offered (must be ignored).
    for (int i = 0; i < 16; i++) begin
      x = 4'(i);
      #1;
      chk("sweep_rst_y", 8'(y8), 8'(ytbl[i]));
      chk("sweep_rst_y2", 8'(y2), 8'(ytbl[i]));
      #9;
    end
    chk_regs_zero("in_reset");
    chk("in_reset_cnt2", 8'(cnt2), 8'h00);
    in_valid  = 1'b0;
    in_valid2 = 1'b0;

    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_regs_zero("after_reset");

    // Combinational sweep out of reset.
    for (int i = 0; i < 16; i++) begin
      x = 4'(i);
      #1;
      chk("sweep_run_y", 8'(y8), 8'(ytbl[i]));
      #9;
    end
    @(negedge clk);

    // Single pulse then idle.
    send8(4'b0111, 1'b1, 1'b1, 8'd1);
    @(negedge clk);
    chk("idle_y_valid", 8'(yv8), 8'h00);
    chk("idle_y_q_hold", 8'(yq8), 8'h01);

    // Plain clear.
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk_regs_zero("clear");

    // Back-to-back stream.
    send8(4'b0001, 1'b1, 1'b1, 8'd1);
    send8(4'b0011, 1'b0, 1'b1, 8'd1);
    send8(4'b1110, 1'b1, 1'b0, 8'd2);
    send8(4'b1111, 1'b0, 1'b0, 8'd2);
    @(negedge clk);
    chk("stream_drained", 8'(q8.size()), 8'h00);
    chk("stream_end_valid", 8'(yv8), 8'h00);

    // Saturation on the 2-bit counter instance.
    x = 4'b0001;
    in_valid2 = 1'b1;
    e.yq = 1'b1; e.acc = 1'b1; e.cnt = 8'd1; q2.push_back(e);
    e.yq = 1'b1; e.acc = 1'b0; e.cnt = 8'd2; q2.push_back(e);
    e.yq = 1'b1; e.acc = 1'b1; e.cnt = 8'd3; q2.push_back(e);
    e.yq = 1'b1; e.acc = 1'b0; e.cnt = 8'd3; q2.push_back(e);
    e.yq = 1'b1; e.acc = 1'b1; e.cnt = 8'd3; q2.push_back(e);
    repeat (5) @(negedge clk);
    in_valid2 = 1'b0;
    @(negedge clk);
    chk("sat_drained", 8'(q2.size()), 8'h00);
    chk("sat_hold_cnt", 8'(cnt2), 8'd3);

    // Clear wins over a simultaneous sample.
    send8(4'b0001, 1'b1, 1'b1, 8'd3);
    x        = 4'b0001;
    clear    = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    chk_regs_zero("clear_prio");

    // Async reset between edges in the middle of a stream.
    x        = 4'b0001;
    in_valid = 1'b1;
    e.yq = 1'b1; e.acc = 1'b1; e.cnt = 8'd1; q8.push_back(e);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    q8.delete();
    #1;
    chk_regs_zero("async_rst");
    x = 4'b1011;
    #1;
    chk("async_rst_y_a", 8'(y8), 8'h01);
    x = 4'b0110;
    #1;
    chk("async_rst_y_b", 8'(y8), 8'h00);
    @(posedge clk);
    #1;
    chk_regs_zero("rst_hold");
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Fresh start: nothing from the aborted stream survives.
    send8(4'b0111, 1'b1, 1'b1, 8'd1);
    @(negedge clk);
    chk("final_drained8", 8'(q8.size()), 8'h00);
    chk("final_drained2", 8'(q2.size()), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
